// File: rtl/l1_d_pkg.sv
// rtl/l1_d_pkg.sv - shared types and helpers for the set-associative L1 data cache
package l1_d_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITEBACK,
      ST_ALLOCATE,
      ST_FLUSH_SCAN,
      ST_FLUSH_WB,
      ST_FLUSH_DONE
   } state_e;

   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   // Extract a w-bit field starting at bit lsb of a (zero-extended) byte address.
   function automatic logic [63:0] addr_field(input logic [63:0] a,
                                              input int unsigned lsb,
                                              input int unsigned w);
      return (a >> lsb) & ((64'd1 << w) - 64'd1);
   endfunction

endpackage

// File: rtl/l1_d_way_array.sv
// rtl/l1_d_way_array.sv - one cache way: valid/dirty/tag/line storage per set
// Async read; strobed word write marks dirty, line fill marks valid and clean.
module l1_d_way_array
   import l1_d_pkg::*;
#(
   parameter int SETS   = 64,
   parameter int IDX_W  = 6,
   parameter int TAG_W  = 20,
   parameter int LINE_W = 512,
   parameter int DATA_W = 32,
   parameter int WSEL_W = 4
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic [IDX_W-1:0]    idx_i,
   output logic                valid_o,
   output logic                dirty_o,
   output logic [TAG_W-1:0]    tag_o,
   output logic [LINE_W-1:0]   line_o,
   input  logic                word_we_i,
   input  logic [WSEL_W-1:0]   wsel_i,
   input  logic [DATA_W/8-1:0] wstrb_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic                line_we_i,
   input  logic [TAG_W-1:0]    tag_i,
   input  logic [LINE_W-1:0]   line_i,
   input  logic                clr_dirty_i,
   input  logic                inval_i
);

   logic [SETS-1:0]   valid_q;
   logic [SETS-1:0]   dirty_q;
   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [LINE_W-1:0] line_mem [SETS];

   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];
   assign tag_o   = tag_mem[idx_i];
   assign line_o  = line_mem[idx_i];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we_i) begin
         valid_q[idx_i] <= 1'b1;
         dirty_q[idx_i] <= 1'b0;
      end else if (inval_i) begin
         valid_q[idx_i] <= 1'b0;
         dirty_q[idx_i] <= 1'b0;
      end else if (clr_dirty_i) begin
         dirty_q[idx_i] <= 1'b0;
      end else if (word_we_i) begin
         dirty_q[idx_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (line_we_i) begin
         tag_mem[idx_i]  <= tag_i;
         line_mem[idx_i] <= line_i;
      end else if (word_we_i) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (wstrb_i[b])
               line_mem[idx_i][int'(wsel_i)*DATA_W + b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/l1_d_cache_assoc.sv
// rtl/l1_d_cache_assoc.sv - set-associative write-back write-allocate L1 data cache
// Hit path is combinational; misses and flush walk run through the FSM below.
module l1_d_cache_assoc
   import l1_d_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LINE_W = 512,
   parameter int SETS   = 64,
   parameter int WAYS   = 2
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic [ADDR_W-1:0]   addr_C_L1,
   input  logic                read_C_L1,
   input  logic                write_C_L1,
   input  logic [DATA_W/8-1:0] wstrb_C_L1,
   input  logic [DATA_W-1:0]   write_data_C_L1,
   input  logic                flush,
   output logic [DATA_W-1:0]   read_data_L1_C,
   output logic                stall,
   output logic                flush_done,
   output logic                read_L1_L2,
   output logic                write_L1_L2,
   output logic [ADDR_W-1:0]   addr_L1_L2,
   output logic [LINE_W-1:0]   write_data_L1_L2,
   input  logic [LINE_W-1:0]   read_data_L2_L1,
   input  logic                ready_L2_L1
);

   localparam int OFF_W  = $clog2(LINE_W/8);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int WSEL_W = $clog2(LINE_W/DATA_W);
   localparam int BYTE_W = $clog2(DATA_W/8);
   localparam int WAY_W  = clog2_min1(WAYS);
   localparam int CNT_W  = clog2_min1(SETS*WAYS) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SETS*WAYS - 1);

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [WAY_W-1:0]    victim_q, victim_d;
   logic                vic_valid_q;
   logic [WAY_W-1:0]    rr_q [SETS];
   logic                read_q, write_q, flush_done_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LINE_W-1:0]   wdata_q;

   logic [63:0]         addr64;
   logic [TAG_W-1:0]    req_tag;
   logic [IDX_W-1:0]    req_idx, cnt_set, idx_sel;
   logic [WSEL_W-1:0]   req_wsel;
   logic [WAY_W-1:0]    cnt_way, hit_way;

   logic [WAYS-1:0]     way_valid, way_dirty, hit_vec;
   logic [WAYS-1:0]     word_we, line_we, clr_dirty, inval;
   logic [TAG_W-1:0]    way_tag  [WAYS];
   logic [LINE_W-1:0]   way_line [WAYS];
   logic [LINE_W-1:0]   sel_line;

   logic                idle, req, hit, flushing;
   logic                ent_valid, ent_dirty;

   assign addr64   = 64'(addr_C_L1);
   assign req_tag  = TAG_W'(addr_field(addr64, OFF_W + IDX_W, TAG_W));
   assign req_idx  = IDX_W'(addr_field(addr64, OFF_W, IDX_W));
   assign req_wsel = WSEL_W'(addr_field(addr64, BYTE_W, WSEL_W));
   assign cnt_set  = IDX_W'(cnt_q / CNT_W'(WAYS));
   assign cnt_way  = WAY_W'(cnt_q % CNT_W'(WAYS));

   assign idle     = (state_q == ST_IDLE);
   assign flushing = (state_q == ST_FLUSH_SCAN) || (state_q == ST_FLUSH_WB);
   assign idx_sel  = flushing ? cnt_set : req_idx;
   assign req      = read_C_L1 || write_C_L1;
   assign hit      = |hit_vec;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      l1_d_way_array #(
         .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W),
         .LINE_W(LINE_W), .DATA_W(DATA_W), .WSEL_W(WSEL_W)
      ) u_way (
         .clk(clk), .nrst(nrst), .idx_i(idx_sel),
         .valid_o(way_valid[w]), .dirty_o(way_dirty[w]),
         .tag_o(way_tag[w]), .line_o(way_line[w]),
         .word_we_i(word_we[w]), .wsel_i(req_wsel),
         .wstrb_i(wstrb_C_L1), .wdata_i(write_data_C_L1),
         .line_we_i(line_we[w]), .tag_i(req_tag), .line_i(read_data_L2_L1),
         .clr_dirty_i(clr_dirty[w]), .inval_i(inval[w])
      );
      assign hit_vec[w] = way_valid[w] && (way_tag[w] == req_tag);
   end

   // Descending loops leave the lowest-numbered match selected.
   always_comb begin
      hit_way  = '0;
      victim_d = rr_q[req_idx];
      for (int w = WAYS-1; w >= 0; w--) begin
         if (hit_vec[w])    hit_way  = WAY_W'(w);
         if (!way_valid[w]) victim_d = WAY_W'(w);
      end
   end

   assign ent_valid = way_valid[cnt_way];
   assign ent_dirty = way_dirty[cnt_way];
   assign sel_line  = way_line[hit_way];

   always_comb begin
      word_we   = '0;
      line_we   = '0;
      clr_dirty = '0;
      inval     = '0;
      for (int w = 0; w < WAYS; w++) begin
         word_we[w]   = idle && !flush && write_C_L1 && hit_vec[w];
         line_we[w]   = (state_q == ST_ALLOCATE) && ready_L2_L1 && (victim_q == WAY_W'(w));
         clr_dirty[w] = (state_q == ST_WRITEBACK) && ready_L2_L1 && (victim_q == WAY_W'(w));
         inval[w]     = (cnt_way == WAY_W'(w)) &&
                        (((state_q == ST_FLUSH_SCAN) && !(ent_valid && ent_dirty)) ||
                         ((state_q == ST_FLUSH_WB) && ready_L2_L1));
      end
   end

   assign read_data_L1_C   = (idle && hit) ? sel_line[int'(req_wsel)*DATA_W +: DATA_W] : '0;
   assign stall            = nrst && (!idle || flush || (req && !hit));
   assign flush_done       = flush_done_q;
   assign read_L1_L2       = read_q;
   assign write_L1_L2      = write_q;
   assign addr_L1_L2       = addr_q;
   assign write_data_L1_L2 = wdata_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         victim_q     <= '0;
         vic_valid_q  <= 1'b0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         flush_done_q <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (flush) begin
                  cnt_q   <= '0;
                  state_q <= ST_FLUSH_SCAN;
               end else if (req && !hit) begin
                  victim_q    <= victim_d;
                  vic_valid_q <= way_valid[victim_d];
                  if (way_valid[victim_d] && way_dirty[victim_d]) begin
                     write_q <= 1'b1;
                     addr_q  <= {way_tag[victim_d], req_idx, {OFF_W{1'b0}}};
                     wdata_q <= way_line[victim_d];
                     state_q <= ST_WRITEBACK;
                  end else begin
                     read_q  <= 1'b1;
                     addr_q  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                     state_q <= ST_ALLOCATE;
                  end
               end
            end
            ST_WRITEBACK: begin
               if (ready_L2_L1) begin
                  write_q <= 1'b0;
                  read_q  <= 1'b1;
                  addr_q  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                  state_q <= ST_ALLOCATE;
               end
            end
            ST_ALLOCATE: begin
               if (ready_L2_L1) begin
                  read_q  <= 1'b0;
                  state_q <= ST_IDLE;
                  if (vic_valid_q && (WAYS > 1))
                     rr_q[req_idx] <= rr_q[req_idx] + WAY_W'(1);
               end
            end
            ST_FLUSH_SCAN: begin
               if (ent_valid && ent_dirty) begin
                  write_q <= 1'b1;
                  addr_q  <= {way_tag[cnt_way], cnt_set, {OFF_W{1'b0}}};
                  wdata_q <= way_line[cnt_way];
                  state_q <= ST_FLUSH_WB;
               end else if (cnt_q == LAST) begin
                  flush_done_q <= 1'b1;
                  state_q      <= ST_FLUSH_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_FLUSH_WB: begin
               if (ready_L2_L1) begin
                  write_q <= 1'b0;
                  if (cnt_q == LAST) begin
                     flush_done_q <= 1'b1;
                     state_q      <= ST_FLUSH_DONE;
                  end else begin
                     cnt_q   <= cnt_q + CNT_W'(1);
                     state_q <= ST_FLUSH_SCAN;
                  end
               end
            end
            ST_FLUSH_DONE: begin
               flush_done_q <= 1'b0;
               state_q      <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l1_d_cache_assoc.sv
// tb/tb_l1_d_cache_assoc.sv - directed table-driven bench for l1_d_cache_assoc
// L2 fill line word i of tag t is 0xA5A5_0000 | (i << 8) | t[7:0].
module tb_l1_d_cache_assoc;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LINE_W = 512;
   localparam int SETS   = 64;
   localparam int WAYS   = 2;

   logic              clk = 1'b0;
   logic              nrst;
   logic [31:0]       addr_C_L1;
   logic              read_C_L1, write_C_L1, flush;
   logic [3:0]        wstrb_C_L1;
   logic [31:0]       write_data_C_L1;
   logic [31:0]       read_data_L1_C;
   logic              stall, flush_done, read_L1_L2, write_L1_L2, ready_L2_L1;
   logic [31:0]       addr_L1_L2;
   logic [LINE_W-1:0] write_data_L1_L2, read_data_L2_L1;

   always #5 clk = ~clk;

   l1_d_cache_assoc #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .SETS(SETS), .WAYS(WAYS)
   ) dut (
      .clk(clk), .nrst(nrst),
      .addr_C_L1(addr_C_L1), .read_C_L1(read_C_L1), .write_C_L1(write_C_L1),
      .wstrb_C_L1(wstrb_C_L1), .write_data_C_L1(write_data_C_L1), .flush(flush),
      .read_data_L1_C(read_data_L1_C), .stall(stall), .flush_done(flush_done),
      .read_L1_L2(read_L1_L2), .write_L1_L2(write_L1_L2), .addr_L1_L2(addr_L1_L2),
      .write_data_L1_L2(write_data_L1_L2), .read_data_L2_L1(read_data_L2_L1),
      .ready_L2_L1(ready_L2_L1)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic        miss;
      logic        wb;
      logic [31:0] wb_addr;
      logic [31:0] wb_w0;
      logic [31:0] wb_w1;
      int          lat;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs [19];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [3:0] s, input logic [31:0] d, input logic m,
                               input logic wb, input logic [31:0] wa, input logic [31:0] w0,
                               input logic [31:0] w1, input int lat, input logic [31:0] r);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = a; v.strb = s; v.wdata = d; v.miss = m;
      v.wb = wb; v.wb_addr = wa; v.wb_w0 = w0; v.wb_w1 = w1; v.lat = lat; v.rdata = r;
      return v;
   endfunction

   function automatic logic [LINE_W-1:0] fill_line(input logic [31:0] a);
      logic [LINE_W-1:0] l;
      for (int i = 0; i < LINE_W/32; i++)
         l[i*32 +: 32] = 32'hA5A5_0000 | (32'(i) << 8) | {24'h0, a[19:12]};
      return l;
   endfunction

   task automatic wait_sig(input bit want_wr, input string name, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if (want_wr ? write_L1_L2 : read_L1_L2) ok = 1'b1;
      end
      chk({name, " req seen"}, 64'(ok), 64'(1));
   endtask

   task automatic l2_serve(input string name, input bit is_wb, input logic [31:0] exp_addr,
                           input logic [31:0] w0, input logic [31:0] w1, input int lat,
                           input logic [31:0] fill_addr);
      bit ok;
      wait_sig(is_wb, name, ok);
      if (!ok) return;
      chk({name, " addr"}, 64'(addr_L1_L2), 64'(exp_addr));
      chk({name, " rd&wr"}, 64'(read_L1_L2 && write_L1_L2), 64'(0));
      if (is_wb) begin
         chk({name, " wb w0"}, 64'(write_data_L1_L2[31:0]), 64'(w0));
         chk({name, " wb w1"}, 64'(write_data_L1_L2[63:32]), 64'(w1));
      end
      for (int c = 0; c < lat; c++) begin
         @(negedge clk);
         chk($sformatf("%s hold%0d req", name, c),
             64'(is_wb ? write_L1_L2 : read_L1_L2), 64'(1));
         chk($sformatf("%s hold%0d addr", name, c), 64'(addr_L1_L2), 64'(exp_addr));
         chk($sformatf("%s hold%0d stall", name, c), 64'(stall), 64'(1));
         if (is_wb)
            chk($sformatf("%s hold%0d w1", name, c), 64'(write_data_L1_L2[63:32]), 64'(w1));
      end
      ready_L2_L1 = 1'b1;
      if (!is_wb) read_data_L2_L1 = fill_line(fill_addr);
      @(posedge clk);
      #1 ready_L2_L1 = 1'b0;
   endtask

   task automatic access(input int i);
      vec_t v;
      v = vecs[i];
      read_C_L1 = v.rd; write_C_L1 = v.wr; addr_C_L1 = v.addr;
      wstrb_C_L1 = v.strb; write_data_C_L1 = v.wdata;
      @(negedge clk);
      chk($sformatf("v%0d stall", i), 64'(stall), 64'(v.miss));
      if (v.miss) begin
         if (v.wb) l2_serve($sformatf("v%0d wb", i), 1'b1, v.wb_addr, v.wb_w0, v.wb_w1, v.lat, 32'h0);
         l2_serve($sformatf("v%0d fill", i), 1'b0, v.addr & ~32'h3F, 32'h0, 32'h0, v.lat, v.addr);
         @(negedge clk);
         chk($sformatf("v%0d stall after fill", i), 64'(stall), 64'(0));
      end else begin
         chk($sformatf("v%0d no L2", i), 64'(read_L1_L2 || write_L1_L2), 64'(0));
      end
      if (v.rd && !v.wr)
         chk($sformatf("v%0d rdata", i), 64'(read_data_L1_C), 64'(v.rdata));
      @(posedge clk);
      #1;
      read_C_L1 = 1'b0; write_C_L1 = 1'b0;
   endtask

   initial begin
      logic [31:0] fl_addr [2];
      logic [31:0] fl_w0   [2];
      int          n_wb, done_at;
      bit          stall_ok, ok;

      //        rd wr addr          strb  wdata          miss wb wb_addr        wb_w0          wb_w1          lat rdata
      vecs[0]  = mk(1, 0, 32'h0000_1040, 4'h0, 32'h0,         1, 0, 32'h0,         32'h0,         32'h0,         2,  32'hA5A5_0001);
      vecs[1]  = mk(1, 0, 32'h0000_1040, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0,         0,  32'hA5A5_0001);
      vecs[2]  = mk(0, 1, 32'h0000_1044, 4'h3, 32'hDEAD_BEEF, 0, 0, 32'h0,         32'h0,         32'h0,         0,  32'h0);
      vecs[3]  = mk(1, 0, 32'h0000_1044, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0,         0,  32'hA5A5_BEEF);
      vecs[4]  = mk(1, 0, 32'h0000_2040, 4'h0, 32'h0,         1, 0, 32'h0,         32'h0,         32'h0,         0,  32'hA5A5_0002);
      vecs[5]  = mk(1, 0, 32'h0000_3048, 4'h0, 32'h0,         1, 1, 32'h0000_1040, 32'hA5A5_0001, 32'hA5A5_BEEF, 20, 32'hA5A5_0203);
      vecs[6]  = mk(1, 0, 32'h0000_2040, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0,         0,  32'hA5A5_0002);
      vecs[7]  = mk(1, 0, 32'h0000_1040, 4'h0, 32'h0,         1, 0, 32'h0,         32'h0,         32'h0,         1,  32'hA5A5_0001);
      vecs[8]  = mk(1, 0, 32'h0000_3040, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0,         0,  32'hA5A5_0003);
      vecs[9]  = mk(1, 0, 32'h0000_2040, 4'h0, 32'h0,         1, 0, 32'h0,         32'h0,         32'h0,         0,  32'hA5A5_0002);
      vecs[10] = mk(0, 1, 32'h0000_0080, 4'hF, 32'h1234_5678, 1, 0, 32'h0,         32'h0,         32'h0,         0,  32'h0);
      vecs[11] = mk(1, 0, 32'h0000_0080, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0,         0,  32'h1234_5678);
      vecs[12] = mk(0, 1, 32'h0000_1040, 4'h8, 32'h7700_0000, 0, 0, 32'h0,         32'h0,         32'h0,         0,  32'h0);
      vecs[13] = mk(1, 0, 32'h0000_1040, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0,         0,  32'h77A5_0001);
      vecs[14] = mk(1, 0, 32'h0000_1040, 4'h0, 32'h0,         1, 0, 32'h0,         32'h0,         32'h0,         0,  32'hA5A5_0001);
      vecs[15] = mk(1, 0, 32'h0000_0080, 4'h0, 32'h0,         1, 0, 32'h0,         32'h0,         32'h0,         0,  32'hA5A5_0000);
      vecs[16] = mk(1, 1, 32'h0000_0084, 4'hF, 32'hCAFE_F00D, 0, 0, 32'h0,         32'h0,         32'h0,         0,  32'h0);
      vecs[17] = mk(1, 0, 32'h0000_0084, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0,         0,  32'hCAFE_F00D);
      vecs[18] = mk(1, 0, 32'h0000_1040, 4'h0, 32'h0,         1, 0, 32'h0,         32'h0,         32'h0,         3,  32'hA5A5_0001);

      nrst = 1'b0; addr_C_L1 = '0; read_C_L1 = 1'b0; write_C_L1 = 1'b0; flush = 1'b0;
      wstrb_C_L1 = '0; write_data_C_L1 = '0; read_data_L2_L1 = '0; ready_L2_L1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset stall",      64'(stall),            64'(0));
      chk("reset flush_done", 64'(flush_done),       64'(0));
      chk("reset rd/wr L2",   64'({read_L1_L2, write_L1_L2}), 64'(0));
      chk("reset addr L2",    64'(addr_L1_L2),       64'(0));
      chk("reset wdata L2",   64'(write_data_L1_L2[63:0]), 64'(0));
      chk("reset rdata",      64'(read_data_L1_C),   64'(0));
      @(posedge clk);
      #1 nrst = 1'b1;

      for (int i = 0; i <= 13; i++) access(i);

      // Flush while a hitting load is also presented: flush must win.
      fl_addr[0] = 32'h0000_1040; fl_w0[0] = 32'h77A5_0001;
      fl_addr[1] = 32'h0000_0080; fl_w0[1] = 32'h1234_5678;
      flush = 1'b1; read_C_L1 = 1'b1; addr_C_L1 = 32'h0000_1040;
      @(negedge clk);
      chk("flush wins stall", 64'(stall), 64'(1));
      @(posedge clk);
      #1 flush = 1'b0; read_C_L1 = 1'b0;
      n_wb = 0; done_at = -1; stall_ok = 1'b1;
      for (int c = 0; c < 400 && done_at < 0; c++) begin
         @(negedge clk);
         if (!stall) stall_ok = 1'b0;
         if (write_L1_L2) begin
            if (n_wb < 2) begin
               chk($sformatf("flush wb%0d addr", n_wb), 64'(addr_L1_L2), 64'(fl_addr[n_wb]));
               chk($sformatf("flush wb%0d w0", n_wb), 64'(write_data_L1_L2[31:0]), 64'(fl_w0[n_wb]));
            end
            n_wb++;
            ready_L2_L1 = 1'b1;
         end
         if (flush_done) done_at = c;
         @(posedge clk);
         #1 ready_L2_L1 = 1'b0;
      end
      chk("flush wb count", 64'(n_wb), 64'(2));
      chk("flush_done cycle", 64'(done_at), 64'(SETS*WAYS + 2));
      chk("flush stall held", 64'(stall_ok), 64'(1));
      @(negedge clk);
      chk("flush_done one pulse", 64'(flush_done), 64'(0));
      chk("idle after flush", 64'(stall), 64'(0));
      @(posedge clk);
      #1;

      for (int i = 14; i <= 17; i++) access(i);

      // Reset asserted while a fill is outstanding.
      read_C_L1 = 1'b1; addr_C_L1 = 32'h0000_5040;
      @(negedge clk);
      chk("rst-test miss stall", 64'(stall), 64'(1));
      wait_sig(1'b0, "rst-test fill", ok);
      @(negedge clk);
      #2 nrst = 1'b0;
      #1;
      chk("rst read_L1_L2 drop", 64'(read_L1_L2), 64'(0));
      chk("rst stall drop",      64'(stall),      64'(0));
      chk("rst addr clear",      64'(addr_L1_L2), 64'(0));
      @(posedge clk);
      #1 nrst = 1'b1; read_C_L1 = 1'b0;
      access(18);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
